// File: rtl/rf_wb_scheduler_if.sv
// Bundle for the writeback scheduler: issue check, ALU and LSU writeback requests,
// and the shared register-file write port with the busy scoreboard.
interface rf_wb_scheduler_if #(
  parameter int XLEN = 32
);
  logic            iss_valid;
  logic [4:0]      iss_rs1;
  logic [4:0]      iss_rs2;
  logic [4:0]      iss_rd;
  logic            iss_long;
  logic            iss_stall;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            pipe_hold;
  logic            we3;
  logic [4:0]      wa3;
  logic [XLEN-1:0] wd3;
  logic [31:0]     busy;
  logic            hold_err;

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_long,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output iss_stall, lsu_ready, pipe_hold, we3, wa3, wd3, busy, hold_err
  );

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_long,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  iss_stall, lsu_ready, pipe_hold, we3, wa3, wd3, busy, hold_err
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Arbitrates the single register-file write port between ALU and LSU writebacks,
// tracks LSU-owed destinations and stalls issue on hazards against them.
module rf_wb_scheduler #(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = 32
) (
  input logic              clk,
  input logic              rst_n,
  rf_wb_scheduler_if.slave bus
);
  typedef enum logic {NORMAL, FORCE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            pipe_hold_q, pipe_hold_d;
  logic            hold_err_q, hold_err_d;
  logic            we3_q, we3_d;
  logic [4:0]      wa3_q, wa3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  logic            src_lsu_q, src_lsu_d;
  logic [31:0]     busy_q, busy_d;

  logic alu_win, lsu_ready, lsu_acc, iss_stall, iss_acc;

  always_comb begin
    alu_win = bus.alu_valid && (bus.alu_rd != 5'd0);
    // In FORCE the LSU is guaranteed the port unless the ALU ignores the hold.
    lsu_ready = (state_q == FORCE) ? !alu_win
                                   : (!bus.alu_valid || (bus.alu_rd == 5'd0));
    lsu_acc   = bus.lsu_valid && lsu_ready;

    iss_stall = bus.iss_valid && (busy_q[bus.iss_rs1] || busy_q[bus.iss_rs2] ||
                                  (bus.iss_long && busy_q[bus.iss_rd]) || pipe_hold_q);
    iss_acc   = bus.iss_valid && !iss_stall && bus.iss_long && (bus.iss_rd != 5'd0);

    we3_d     = 1'b0;
    wa3_d     = wa3_q;
    wd3_d     = wd3_q;
    src_lsu_d = 1'b0;
    if (alu_win) begin
      we3_d = 1'b1;
      wa3_d = bus.alu_rd;
      wd3_d = bus.alu_data;
    end else if (lsu_acc && (bus.lsu_rd != 5'd0)) begin
      we3_d     = 1'b1;
      wa3_d     = bus.lsu_rd;
      wd3_d     = bus.lsu_data;
      src_lsu_d = 1'b1;
    end

    cnt_d       = 4'd0;
    state_d     = NORMAL;
    pipe_hold_d = 1'b0;
    hold_err_d  = hold_err_q || ((state_q == FORCE) && alu_win);
    if (state_q == NORMAL && bus.lsu_valid && !lsu_ready) begin
      cnt_d = (cnt_q < 4'(STARVE_LIMIT)) ? cnt_q + 4'd1 : cnt_q;
      if (cnt_d == 4'(STARVE_LIMIT)) begin
        state_d     = FORCE;
        pipe_hold_d = 1'b1;
      end
    end

    // Clear and set never hit the same bit: a WAW on a busy rd stalls issue.
    busy_d = busy_q;
    if (we3_q && src_lsu_q) busy_d[wa3_q] = 1'b0;
    if (iss_acc) busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= NORMAL;
      cnt_q       <= 4'd0;
      pipe_hold_q <= 1'b0;
      hold_err_q  <= 1'b0;
      we3_q       <= 1'b0;
      wa3_q       <= 5'd0;
      wd3_q       <= '0;
      src_lsu_q   <= 1'b0;
      busy_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pipe_hold_q <= pipe_hold_d;
      hold_err_q  <= hold_err_d;
      we3_q       <= we3_d;
      wa3_q       <= wa3_d;
      wd3_q       <= wd3_d;
      src_lsu_q   <= src_lsu_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.iss_stall = iss_stall;
  assign bus.lsu_ready = lsu_ready;
  assign bus.pipe_hold = pipe_hold_q;
  assign bus.hold_err  = hold_err_q;
  assign bus.we3       = we3_q;
  assign bus.wa3       = wa3_q;
  assign bus.wd3       = wd3_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench: vector table for arbitration, hand sequences for the
// scoreboard, starvation, conflict and reset cases; writes checked via a queue.
module tb_rf_wb_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rf_wb_scheduler_if #(.XLEN(32)) bus ();
  rf_wb_scheduler #(.STARVE_LIMIT(4), .XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int          cyc;
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        rdy;
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;
  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input logic [4:0] wa, input logic [31:0] wd);
    wr_t e;
    e.cyc = cyc + 1;
    e.wa  = wa;
    e.wd  = wd;
    exp_q.push_back(e);
  endtask

  task automatic idle_in();
    bus.iss_valid = 1'b0; bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd0;
    bus.iss_rd = 5'd0; bus.iss_long = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic lng);
    bus.iss_valid = 1'b1; bus.iss_rs1 = rs1; bus.iss_rs2 = rs2;
    bus.iss_rd = rd; bus.iss_long = lng;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid = 1'b1; bus.alu_rd = rd; bus.alu_data = d;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] d);
    bus.lsu_valid = 1'b1; bus.lsu_rd = rd; bus.lsu_data = d;
  endtask

  // Write-port monitor: every we3 pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missed_write_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (bus.we3) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we3", {31'd0, bus.we3}, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_cycle", cyc, e.cyc);
          check("wa3", {27'd0, bus.wa3}, {27'd0, e.wa});
          check("wd3", bus.wd3, e.wd);
        end
      end
    end
  end

  initial begin
    vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
    vt[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 5'd0,  32'h0};
    vt[2]  = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4, 32'h22, 1'b0, 1'b1, 5'd3,  32'h11};
    vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4, 32'h22, 1'b1, 1'b1, 5'd4,  32'h22};
    vt[4]  = '{1'b1, 5'd0,  32'h55,       1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 5'd9,  32'h99};
    vt[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'hAA, 1'b1, 1'b0, 5'd0,  32'h0};
    vt[6]  = '{1'b1, 5'd0,  32'hBB,       1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 5'd0,  32'h0};
    vt[7]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd6, 32'h66, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF};
    vt[8]  = '{1'b1, 5'd30, 32'h12345678, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd30, 32'h12345678};
    vt[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6, 32'h66, 1'b1, 1'b1, 5'd6,  32'h66};
    vt[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 5'd0,  32'h0};

    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we3", {31'd0, bus.we3}, 32'd0);
    check("rst_wa3", {27'd0, bus.wa3}, 32'd0);
    check("rst_wd3", bus.wd3, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_pipe_hold", {31'd0, bus.pipe_hold}, 32'd0);
    check("rst_hold_err", {31'd0, bus.hold_err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Arbitration vectors
    for (int i = 0; i < 11; i++) begin
      step();
      if (vt[i].av) alu(vt[i].ard, vt[i].ad);
      if (vt[i].lv) lsu(vt[i].lrd, vt[i].ld);
      if (vt[i].wr) push_wr(vt[i].wa, vt[i].wd);
      @(negedge clk);
      check($sformatf("vec%0d_lsu_ready", i), {31'd0, bus.lsu_ready}, {31'd0, vt[i].rdy});
    end
    check("vec_busy_untouched", bus.busy, 32'd0);

    // Scoreboard RAW stall on x7
    step(); issue(5'd0, 5'd0, 5'd7, 1'b1);
    @(negedge clk); check("a_issue_long_stall", {31'd0, bus.iss_stall}, 32'd0);
    step(); issue(5'd7, 5'd0, 5'd8, 1'b0);
    @(negedge clk); check("a_busy7", bus.busy, 32'h80);
    check("a_raw_stall", {31'd0, bus.iss_stall}, 32'd1);
    step(); issue(5'd7, 5'd0, 5'd8, 1'b0); lsu(5'd7, 32'h77); push_wr(5'd7, 32'h77);
    @(negedge clk); check("a_stall_lsu_cycle", {31'd0, bus.iss_stall}, 32'd1);
    step(); issue(5'd7, 5'd0, 5'd8, 1'b0);
    @(negedge clk); check("a_stall_we3_cycle", {31'd0, bus.iss_stall}, 32'd1);
    check("a_busy_we3_cycle", bus.busy, 32'h80);
    step(); issue(5'd7, 5'd0, 5'd8, 1'b0);
    @(negedge clk); check("a_stall_drop", {31'd0, bus.iss_stall}, 32'd0);
    check("a_busy_clear", bus.busy, 32'd0);

    // Set and clear of different bits in one cycle, then WAW stall
    step(); issue(5'd0, 5'd0, 5'd7, 1'b1);
    step(); lsu(5'd7, 32'h70); push_wr(5'd7, 32'h70);
    step(); issue(5'd3, 5'd4, 5'd10, 1'b1);
    @(negedge clk); check("d_issue_during_clear", {31'd0, bus.iss_stall}, 32'd0);
    step(); issue(5'd0, 5'd0, 5'd10, 1'b1);
    @(negedge clk); check("d_busy_swap", bus.busy, 32'h400);
    check("d_waw_stall", {31'd0, bus.iss_stall}, 32'd1);
    step(); issue(5'd0, 5'd10, 5'd11, 1'b0); lsu(5'd10, 32'hA0); push_wr(5'd10, 32'hA0);
    @(negedge clk); check("d_raw_rs2_stall", {31'd0, bus.iss_stall}, 32'd1);
    step(); step();
    @(negedge clk); check("d_busy_clear", bus.busy, 32'd0);

    // Starvation, ALU backs off during the hold
    for (int i = 0; i < 4; i++) begin
      step(); alu(5'd1, 32'h100 + i); lsu(5'd2, 32'hAB); push_wr(5'd1, 32'h100 + i);
      @(negedge clk);
      check($sformatf("b%0d_lsu_ready", i), {31'd0, bus.lsu_ready}, 32'd0);
      check($sformatf("b%0d_pipe_hold", i), {31'd0, bus.pipe_hold}, 32'd0);
    end
    step(); lsu(5'd2, 32'hAB); issue(5'd0, 5'd0, 5'd0, 1'b0); push_wr(5'd2, 32'hAB);
    @(negedge clk);
    check("b_pipe_hold", {31'd0, bus.pipe_hold}, 32'd1);
    check("b_force_ready", {31'd0, bus.lsu_ready}, 32'd1);
    check("b_hold_stall", {31'd0, bus.iss_stall}, 32'd1);
    step();
    @(negedge clk);
    check("b_pipe_hold_fall", {31'd0, bus.pipe_hold}, 32'd0);
    check("b_no_hold_err", {31'd0, bus.hold_err}, 32'd0);

    // Starvation, ALU ignores the hold
    for (int i = 0; i < 4; i++) begin
      step(); alu(5'd1, 32'h200 + i); lsu(5'd2, 32'hCD); push_wr(5'd1, 32'h200 + i);
    end
    step(); alu(5'd1, 32'h2FF); lsu(5'd2, 32'hCD); push_wr(5'd1, 32'h2FF);
    @(negedge clk);
    check("c_pipe_hold", {31'd0, bus.pipe_hold}, 32'd1);
    check("c_conflict_ready", {31'd0, bus.lsu_ready}, 32'd0);
    step();
    @(negedge clk);
    check("c_hold_err_set", {31'd0, bus.hold_err}, 32'd1);
    check("c_pipe_hold_fall", {31'd0, bus.pipe_hold}, 32'd0);
    step();
    @(negedge clk); check("c_hold_err_sticky", {31'd0, bus.hold_err}, 32'd1);

    // ALU to x0 alongside LSU, x0 sources while busy
    step(); issue(5'd0, 5'd0, 5'd12, 1'b1);
    step(); alu(5'd0, 32'h5); lsu(5'd9, 32'h99); issue(5'd0, 5'd0, 5'd0, 1'b0);
    push_wr(5'd9, 32'h99);
    @(negedge clk);
    check("f_lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
    check("f_x0_no_stall", {31'd0, bus.iss_stall}, 32'd0);
    check("f_busy12", bus.busy, 32'h1000);
    step(); alu(5'd13, 32'h1313);

    // Asynchronous reset mid-operation with a write in flight
    @(posedge clk);
    #1;
    idle_in();
    check("g_pre_reset_we3", {31'd0, bus.we3}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("g_rst_we3", {31'd0, bus.we3}, 32'd0);
    check("g_rst_wa3", {27'd0, bus.wa3}, 32'd0);
    check("g_rst_wd3", bus.wd3, 32'd0);
    check("g_rst_busy", bus.busy, 32'd0);
    check("g_rst_pipe_hold", {31'd0, bus.pipe_hold}, 32'd0);
    check("g_rst_hold_err", {31'd0, bus.hold_err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(); step();
    @(negedge clk);
    check("g_post_we3", {31'd0, bus.we3}, 32'd0);
    check("g_post_busy", bus.busy, 32'd0);

    repeat (3) step();
    check("pending_writes", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
